id_fwd_stage: RTL and testbench
===============================

ID_FWD_STAGE -- requirements
Module: id_fwd_stage

Interface
REQ-001 Parameters (name, default, meaning), each SHALL exist:
  XLEN, 32, datapath width;
  AW, 5, register address width;
  NSRC, 3, number of forwarding sources (index 0 = youngest stage);
  CW, 16, stall counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk in 1 clock;
  rst in 1 reset, synchronous, active-high;
  stall_if in 1 upstream stage held;
  stall_id in 1 this stage held;
  flush in 1 discard ID contents;
  if_valid in 1 IF slot valid;
  if_pc in XLEN IF pc;
  inst_rdata in XLEN sync instruction SRAM data, valid the cycle after the IF->ID load;
  rf_raddr1 out AW = inst[25:21];
  rf_raddr2 out AW = inst[20:16];
  rf_rdata1 in XLEN regfile data 1;
  rf_rdata2 in XLEN regfile data 2;
  fwd_we in NSRC per-source write enable;
  fwd_waddr in NSRC*AW source i at bits [i*AW +: AW];
  fwd_wdata in NSRC*XLEN source i at bits [i*XLEN +: XLEN];
  fwd_pending in NSRC source value not yet available (load in flight);
  id_valid out 1;
  id_pc out XLEN;
  id_inst out XLEN;
  src1 out XLEN resolved operand 1;
  src2 out XLEN resolved operand 2;
  stallreq out 1 load-use stall request;
  stall_cnt out CW stall cycle count.

Function
REQ-003 Register update priority SHALL be: rst, then flush (id_valid<=0, id_pc<=0), then stall_if & !stall_id (bubble: id_valid<=0, id_pc<=0), then !stall_if (load if_valid, if_pc), else hold.
REQ-004 The FSM SHALL have states RUN and HOLD; RUN->HOLD on the first cycle stall_id=1 with id_valid=1, capturing inst_rdata into inst_buf that cycle.
REQ-005 HOLD->RUN SHALL occur on the first cycle stall_id=0, or on flush; HOLD persists while stall_id=1.
REQ-006 id_inst SHALL be 0 when id_valid=0, inst_buf in HOLD, else inst_rdata (RUN); in the capture cycle inst_rdata is used.
REQ-007 srcN resolution SHALL be: raddr=0 -> 0; else lowest i with fwd_we[i] & fwd_waddr[i]==raddr -> fwd_wdata[i]; else rf_rdataN; purely combinational, zero added latency.
REQ-008 stallreq SHALL be 1 iff id_valid and, for either operand, the winning source of REQ-007 has fwd_pending=1; an older pending match shadowed by a younger non-pending match SHALL NOT stall.
REQ-009 stall_cnt SHALL increment each cycle stallreq=1, saturate at 2^CW-1, and be unaffected by flush.
REQ-010 Simultaneous flush and stall_id SHALL flush; stallreq SHALL be 0 in the cycle after flush.

Reset
REQ-011 On rst: id_valid=0, id_pc=0, inst_buf=0, FSM=RUN, stall_cnt=0; id_inst and stallreq therefore 0.
REQ-012 Reset asserted mid-HOLD SHALL abandon the buffered instruction with no residual output.

Structure
REQ-013 Package id_pkg SHALL hold XLEN/AW defaults, the RUN/HOLD state type, and the ZERO_REG constant.
REQ-014 One sub-module, id_fwd_mux (one operand: priority match, zero-reg, pending flag), SHALL be instantiated twice.

Verification
REQ-015 Load if_pc=0x1000, inst=0x3C011234, no matches -> id_valid=1, id_pc=0x1000, id_inst=0x3C011234 next cycle.
REQ-016 fwd_we=3'b011, waddr0=waddr1=5 (raddr1=5), wdata0=0xA, wdata1=0xB -> src1=0xA.
REQ-017 raddr2=8, source1 matches with pending=1, source0 no match -> stallreq=1, stall_cnt +1/cycle; then source0 matches non-pending -> stallreq=0.
REQ-018 stall_id high 3 cycles while inst_rdata changes 0x24020001->0xFFFFFFFF -> id_inst stays 0x24020001 throughout.
REQ-019 stall_if=1, stall_id=0 -> id_valid=0, id_inst=0; flush during HOLD -> id_valid=0, FSM=RUN next cycle.
REQ-020 Raddr=0 with a matching source -> src=0; stall_cnt with CW=2 forced 5 stall cycles -> holds 3.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the decode/forwarding stage: default widths,
// the instruction-hold FSM state type and the hard-wired zero register.
package id_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    // Register number that always reads as zero and never forwards or stalls.
    localparam int ZERO_REG = 0;

    // Bit positions of the two source register fields in the instruction word.
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } id_state_t;

endpackage

// File: rtl/id_fwd_mux.sv
// One operand's bypass selector: youngest enabled matching source wins over
// the register file, register zero is forced to zero, and the winner's pending flag is reported.
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int NSRC = 3
) (
    input  logic [AW-1:0]        raddr,
    input  logic [XLEN-1:0]      rf_rdata,
    input  logic [NSRC-1:0]      fwd_we,
    input  logic [NSRC*AW-1:0]   fwd_waddr,
    input  logic [NSRC*XLEN-1:0] fwd_wdata,
    input  logic [NSRC-1:0]      fwd_pending,
    output logic [XLEN-1:0]      data,
    output logic                 pending
);

    always_comb begin
        data    = rf_rdata;
        pending = 1'b0;
        // Walk oldest to youngest so the lowest-index match is the last write.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == raddr)) begin
                data    = fwd_wdata[i*XLEN +: XLEN];
                pending = fwd_pending[i];
            end
        end
        if (raddr == AW'(ZERO_REG)) begin
            data    = '0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage register with instruction hold buffer, operand bypass and
// load-use stall request; the instruction comes straight from a synchronous SRAM.
//
// state | meaning
// RUN   | id_inst follows the live SRAM read data
// HOLD  | stage is stalled; id_inst replays the word captured on stall entry
module id_fwd_stage
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int NSRC = 3,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_if,
    input  logic                 stall_id,
    input  logic                 flush,
    input  logic                 if_valid,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [XLEN-1:0]      inst_rdata,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NSRC-1:0]      fwd_we,
    input  logic [NSRC*AW-1:0]   fwd_waddr,
    input  logic [NSRC*XLEN-1:0] fwd_wdata,
    input  logic [NSRC-1:0]      fwd_pending,
    output logic                 id_valid,
    output logic [XLEN-1:0]      id_pc,
    output logic [XLEN-1:0]      id_inst,
    output logic [XLEN-1:0]      src1,
    output logic [XLEN-1:0]      src2,
    output logic                 stallreq,
    output logic [CW-1:0]        stall_cnt
);

    id_state_t       state;
    id_state_t       state_nxt;
    logic            capture;
    logic [XLEN-1:0] inst_buf;
    logic            pending1;
    logic            pending2;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (stall_if && !stall_id) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (!stall_if) begin
            id_valid <= if_valid;
            id_pc    <= if_pc;
        end
    end

    // Flush wins over a simultaneous stall, so no capture happens then.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            RUN: begin
                if (!flush && stall_id && id_valid) begin
                    state_nxt = HOLD;
                    capture   = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !stall_id) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            inst_buf <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                inst_buf <= inst_rdata;
            end
        end
    end

    always_comb begin
        id_inst = '0;
        if (id_valid) begin
            id_inst = (state == HOLD) ? inst_buf : inst_rdata;
        end
    end

    assign rf_raddr1 = id_inst[RS_LSB +: AW];
    assign rf_raddr2 = id_inst[RT_LSB +: AW];

    id_fwd_mux #(
        .XLEN (XLEN),
        .AW   (AW),
        .NSRC (NSRC)
    ) u_mux1 (
        .raddr       (rf_raddr1),
        .rf_rdata    (rf_rdata1),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_pending (fwd_pending),
        .data        (src1),
        .pending     (pending1)
    );

    id_fwd_mux #(
        .XLEN (XLEN),
        .AW   (AW),
        .NSRC (NSRC)
    ) u_mux2 (
        .raddr       (rf_raddr2),
        .rf_rdata    (rf_rdata2),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_pending (fwd_pending),
        .data        (src2),
        .pending     (pending2)
    );

    assign stallreq = id_valid && (pending1 || pending2);

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stallreq && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: table of bypass vectors through a scoreboard queue,
// plus hand sequences for hold, flush, reset-in-hold and counter saturation.
module tb_id_fwd_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSRC = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 stall_if;
    logic                 stall_id;
    logic                 flush;
    logic                 if_valid;
    logic [XLEN-1:0]      if_pc;
    logic [XLEN-1:0]      inst_rdata;
    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;
    logic [NSRC-1:0]      fwd_we;
    logic [NSRC*AW-1:0]   fwd_waddr;
    logic [NSRC*XLEN-1:0] fwd_wdata;
    logic [NSRC-1:0]      fwd_pending;

    logic [AW-1:0]   rf_raddr1, rf_raddr2;
    logic            id_valid, stallreq;
    logic [XLEN-1:0] id_pc, id_inst, src1, src2;
    logic [15:0]     stall_cnt;

    logic [AW-1:0]   c2_raddr1, c2_raddr2;
    logic            c2_valid, c2_stallreq;
    logic [XLEN-1:0] c2_pc, c2_inst, c2_src1, c2_src2;
    logic [1:0]      c2_stall_cnt;

    id_fwd_stage #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .CW(16)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .src1(src1), .src2(src2), .stallreq(stallreq), .stall_cnt(stall_cnt)
    );

    id_fwd_stage #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .CW(2)) dut_c2 (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
        .rf_raddr1(c2_raddr1), .rf_raddr2(c2_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
        .id_valid(c2_valid), .id_pc(c2_pc), .id_inst(c2_inst),
        .src1(c2_src1), .src2(c2_src2), .stallreq(c2_stallreq), .stall_cnt(c2_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt16 = 0;
    int exp_cnt2  = 0;

    typedef struct {
        logic [4:0]  rs, rt;
        logic [2:0]  we;
        logic [4:0]  wa0, wa1, wa2;
        logic [31:0] wd0, wd1, wd2;
        logic [2:0]  pend;
        logic [31:0] e_src1, e_src2;
        logic        e_stall;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty: got 0x%08h expected an entry", act);
        end else begin
            e = sb.pop_front();
            chk(e.name, act, e.val);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_cnt16"}, {16'h0, stall_cnt}, exp_cnt16);
        chk({name, "_cnt2"}, {30'h0, c2_stall_cnt}, exp_cnt2);
    endtask

    task automatic cnt_step(input logic s);
        if (s) begin
            if (exp_cnt16 < 65535) exp_cnt16++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_pending = '0;
    endtask

    task automatic set_src(input int i, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic p);
        fwd_we[i] = we;
        fwd_waddr[i*AW +: AW] = a;
        fwd_wdata[i*XLEN +: XLEN] = d;
        fwd_pending[i] = p;
    endtask

    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h0, rs, rt, 16'h0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // rs, rt, we, wa0, wa1, wa2, wd0, wd1, wd2, pend, e_src1, e_src2, e_stall
        vecs[0]  = '{5'd5, 5'd0, 3'b011, 5'd5, 5'd5, 5'd0, 32'hA,    32'hB,  32'h0,  3'b000, 32'hA,   32'h0,   1'b0};
        vecs[1]  = '{5'd5, 5'd0, 3'b010, 5'd5, 5'd5, 5'd0, 32'hA,    32'hB,  32'h0,  3'b000, 32'hB,   32'h0,   1'b0};
        vecs[2]  = '{5'd5, 5'd0, 3'b000, 5'd5, 5'd5, 5'd0, 32'hA,    32'hB,  32'h0,  3'b000, 32'h111, 32'h0,   1'b0};
        vecs[3]  = '{5'd0, 5'd7, 3'b001, 5'd0, 5'd0, 5'd0, 32'hDEAD, 32'h0,  32'h0,  3'b001, 32'h0,   32'h222, 1'b0};
        vecs[4]  = '{5'd3, 5'd9, 3'b100, 5'd0, 5'd0, 5'd9, 32'h0,    32'h0,  32'hC,  3'b000, 32'h111, 32'hC,   1'b0};
        vecs[5]  = '{5'd4, 5'd8, 3'b010, 5'd0, 5'd8, 5'd0, 32'h0,    32'h77, 32'h0,  3'b010, 32'h111, 32'h77,  1'b1};
        vecs[6]  = '{5'd4, 5'd8, 3'b011, 5'd8, 5'd8, 5'd0, 32'h66,   32'h77, 32'h0,  3'b010, 32'h111, 32'h66,  1'b0};
        vecs[7]  = '{5'd4, 5'd8, 3'b000, 5'd8, 5'd8, 5'd8, 32'h1,    32'h2,  32'h3,  3'b111, 32'h111, 32'h222, 1'b0};
        vecs[8]  = '{5'd2, 5'd3, 3'b101, 5'd2, 5'd0, 5'd3, 32'h10,   32'h0,  32'h30, 3'b100, 32'h10,  32'h30,  1'b1};
        vecs[9]  = '{5'd6, 5'd6, 3'b110, 5'd0, 5'd6, 5'd6, 32'h0,    32'h61, 32'h62, 3'b100, 32'h61,  32'h61,  1'b0};
        vecs[10] = '{5'd1, 5'd2, 3'b111, 5'd1, 5'd1, 5'd2, 32'h71,   32'h72, 32'h73, 3'b001, 32'h71,  32'h73,  1'b1};

        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0; if_valid = 1'b0;
        if_pc = '0; inst_rdata = 32'hFFFF_FFFF; rf_rdata1 = '0; rf_rdata2 = '0;
        clear_fwd();
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_stallreq", {31'h0, stallreq}, 32'h0);
        chk_cnt("rst");

        // First load
        tick();
        rst = 1'b0; if_valid = 1'b1; if_pc = 32'h1000;
        tick();
        inst_rdata = 32'h3C01_1234; rf_rdata1 = 32'h111; rf_rdata2 = 32'h55;
        @(negedge clk);
        chk("load_valid", {31'h0, id_valid}, 32'h1);
        chk("load_pc", id_pc, 32'h1000);
        chk("load_inst", id_inst, 32'h3C01_1234);
        chk("load_raddr1", {27'h0, rf_raddr1}, 32'h0);
        chk("load_raddr2", {27'h0, rf_raddr2}, 32'h1);
        chk("load_src1_zero", src1, 32'h0);
        chk("load_src2_rf", src2, 32'h55);

        // Bypass vector table
        rf_rdata2 = 32'h222;
        for (int k = 0; k < 11; k++) begin
            tick();
            inst_rdata  = mk_inst(vecs[k].rs, vecs[k].rt);
            fwd_we      = vecs[k].we;
            fwd_pending = vecs[k].pend;
            fwd_waddr   = {vecs[k].wa2, vecs[k].wa1, vecs[k].wa0};
            fwd_wdata   = {vecs[k].wd2, vecs[k].wd1, vecs[k].wd0};
            sb.push_back('{name: $sformatf("v%0d_src1", k), val: vecs[k].e_src1});
            sb.push_back('{name: $sformatf("v%0d_src2", k), val: vecs[k].e_src2});
            sb.push_back('{name: $sformatf("v%0d_stallreq", k), val: {31'h0, vecs[k].e_stall}});
            sb.push_back('{name: $sformatf("v%0d_inst", k), val: mk_inst(vecs[k].rs, vecs[k].rt)});
            @(negedge clk);
            chk_cnt($sformatf("v%0d", k));
            pop_cmp(src1);
            pop_cmp(src2);
            pop_cmp({31'h0, stallreq});
            pop_cmp(id_inst);
            cnt_step(vecs[k].e_stall);
        end

        // Load-use stall then a younger non-pending match shadows it
        tick();
        clear_fwd();
        inst_rdata = mk_inst(5'd0, 5'd8);
        set_src(1, 1'b1, 5'd8, 32'h88, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("lu%0d_stallreq", c), {31'h0, stallreq}, 32'h1);
            chk_cnt($sformatf("lu%0d", c));
            cnt_step(1'b1);
            tick();
        end
        set_src(0, 1'b1, 5'd8, 32'h99, 1'b0);
        @(negedge clk);
        chk("lu_shadow_stallreq", {31'h0, stallreq}, 32'h0);
        chk("lu_shadow_src2", src2, 32'h99);
        chk_cnt("lu_shadow");
        tick();
        @(negedge clk);
        chk_cnt("lu_after");

        // Hold: instruction must survive SRAM data changing
        tick();
        clear_fwd();
        if_pc = 32'h2000;
        tick();
        inst_rdata = 32'h2402_0001; stall_id = 1'b1; stall_if = 1'b1;
        @(negedge clk);
        chk("hold_capture_inst", id_inst, 32'h2402_0001);
        tick();
        inst_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("hold1_inst", id_inst, 32'h2402_0001);
        chk("hold1_pc", id_pc, 32'h2000);
        chk("hold1_valid", {31'h0, id_valid}, 32'h1);
        tick();
        @(negedge clk);
        chk("hold2_inst", id_inst, 32'h2402_0001);
        tick();
        stall_id = 1'b0;
        @(negedge clk);
        chk("hold_release_inst", id_inst, 32'h2402_0001);
        tick();
        @(negedge clk);
        chk("bubble_valid", {31'h0, id_valid}, 32'h0);
        chk("bubble_inst", id_inst, 32'h0);
        chk("bubble_pc", id_pc, 32'h0);

        // Flush while holding with a pending operand
        tick();
        stall_if = 1'b0; if_pc = 32'h3000;
        tick();
        inst_rdata = 32'h00A0_1234; stall_id = 1'b1; stall_if = 1'b1;
        set_src(2, 1'b1, 5'd5, 32'hEE, 1'b1);
        @(negedge clk);
        chk("fl_pre_stallreq", {31'h0, stallreq}, 32'h1);
        chk("fl_pre_src1", src1, 32'hEE);
        cnt_step(1'b1);
        tick();
        inst_rdata = 32'h0;
        @(negedge clk);
        chk("fl_hold_inst", id_inst, 32'h00A0_1234);
        chk("fl_hold_stallreq", {31'h0, stallreq}, 32'h1);
        cnt_step(1'b1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        cnt_step(1'b1);
        tick();
        flush = 1'b0; stall_if = 1'b0; if_pc = 32'h4000; inst_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("fl_valid", {31'h0, id_valid}, 32'h0);
        chk("fl_pc", id_pc, 32'h0);
        chk("fl_inst", id_inst, 32'h0);
        chk("fl_stallreq", {31'h0, stallreq}, 32'h0);
        chk_cnt("fl");
        tick();
        stall_id = 1'b0;
        clear_fwd();
        @(negedge clk);
        chk("fl_run_inst", id_inst, 32'h0BAD_F00D);
        chk("fl_run_pc", id_pc, 32'h4000);

        // Reset while holding
        tick();
        if_pc = 32'h5000;
        tick();
        inst_rdata = 32'hAAAA_5555; stall_id = 1'b1; stall_if = 1'b1;
        tick();
        inst_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rh_hold_inst", id_inst, 32'hAAAA_5555);
        tick();
        rst = 1'b1;
        tick();
        exp_cnt16 = 0; exp_cnt2 = 0;
        @(negedge clk);
        chk("rh_valid", {31'h0, id_valid}, 32'h0);
        chk("rh_inst", id_inst, 32'h0);
        chk_cnt("rh");
        rst = 1'b0; stall_if = 1'b0; if_pc = 32'h6000; inst_rdata = 32'h1357_2468;
        tick();
        stall_id = 1'b0;
        @(negedge clk);
        chk("rh_run_inst", id_inst, 32'h1357_2468);
        chk("rh_run_pc", id_pc, 32'h6000);

        // Counter saturation on the narrow instance
        tick();
        inst_rdata = mk_inst(5'd0, 5'd8);
        set_src(1, 1'b1, 5'd8, 32'h88, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("sat%0d_stallreq", c), {31'h0, stallreq}, 32'h1);
            chk_cnt($sformatf("sat%0d", c));
            cnt_step(1'b1);
            tick();
        end
        clear_fwd();
        @(negedge clk);
        chk_cnt("sat_end");
        chk("sat_c2_value", {30'h0, c2_stall_cnt}, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
